int_sched: RTL and testbench

Interrupt sequencer for the single-cycle MIPS datapath. It sits beside the instruction decoder and the PC mux. It latches three external request lines, arbitrates them by fixed priority against the in-service level, and redirects the PC to a per-source vector. It keeps a nested EPC stack and returns through ERET. It also suppresses interrupt entry while the core is halted by syscall and for one instruction after each return.

---
 rtl/int_sched.sv | 180 ++++++++++++++++++
 tb/tb_int_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_sched.sv
// Interrupt sequencer: edge-latched requests, fixed-priority nesting, EPC stack, ERET return.
// Latency: irq edge in cycle n -> pending at n+1 -> vector taken at n+2 earliest; ERET is same-cycle.
// Backpressure: entry is held off by in_halt, in_eret and the post-return shadow cycle; requests stay pending.
module int_sched #(
   parameter logic [31:0] VEC_BASE = 32'h0000_0400
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic [2:0]  in_irq,
   input  logic [31:0] in_pc_next,
   input  logic        in_eret,
   input  logic        in_halt,
   input  logic        in_mask_we,
   input  logic [2:0]  in_mask_wdata,
   output logic        out_take,
   output logic [31:0] out_vector,
   output logic        out_eret_take,
   output logic [31:0] out_epc,
   output logic [2:0]  out_pending,
   output logic [2:0]  out_inservice,
   output logic [2:0]  out_mask
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_TAKE   = 2'd1,
      ST_SHADOW = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_irq_q;
   logic [2:0]  r_pending;
   logic [2:0]  r_inservice;
   logic [2:0]  r_mask;
   logic [1:0]  r_src;
   logic [1:0]  r_ptr;
   logic [31:0] r_stack [0:2];

   logic [2:0]  w_irq_rise;
   logic [2:0]  w_above;
   logic [2:0]  w_lvl_oh;
   logic [2:0]  w_elig;
   logic        w_cand_vld;
   logic [1:0]  w_cand_idx;
   logic        w_enter;
   logic        w_eret_take;
   logic [2:0]  w_src_oh;

   assign w_irq_rise = in_irq & ~r_irq_q;

   // Level of the highest source in service: the sources allowed above it and its one-hot bit.
   always_comb begin
      w_above  = 3'b111;
      w_lvl_oh = 3'b000;
      if (r_inservice[2]) begin
         w_above  = 3'b000;
         w_lvl_oh = 3'b100;
      end else if (r_inservice[1]) begin
         w_above  = 3'b100;
         w_lvl_oh = 3'b010;
      end else if (r_inservice[0]) begin
         w_above  = 3'b110;
         w_lvl_oh = 3'b001;
      end
   end

   // Fixed-priority pick among enabled pending sources that outrank the current level.
   always_comb begin
      w_elig     = r_pending & r_mask & w_above;
      w_cand_vld = |w_elig;
      w_cand_idx = 2'd0;
      if (w_elig[2]) begin
         w_cand_idx = 2'd2;
      end else if (w_elig[1]) begin
         w_cand_idx = 2'd1;
      end
   end

   // Next-state decode; ERET wins over entry in RUN, TAKE and SHADOW each last one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      w_eret_take = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (in_eret && (r_inservice != 3'b000)) begin
               w_eret_take = 1'b1;
               w_state_nxt = ST_SHADOW;
            end else if (w_cand_vld && !in_halt && !in_eret) begin
               w_enter     = 1'b1;
               w_state_nxt = ST_TAKE;
            end
         end
         ST_TAKE:   w_state_nxt = ST_RUN;
         ST_SHADOW: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // One-hot of the source being entered, used to clear pending and set in-service.
   always_comb begin
      w_src_oh = 3'b000;
      if (r_state == ST_TAKE) begin
         w_src_oh[r_src] = 1'b1;
      end
   end

   // State register, chosen source, edge history and mask.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state <= ST_RUN;
         r_src   <= 2'd0;
         r_irq_q <= 3'b000;
         r_mask  <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         r_irq_q <= in_irq;
         if (w_enter) begin
            r_src <= w_cand_idx;
         end
         if (in_mask_we) begin
            r_mask <= in_mask_wdata;
         end
      end
   end

   // Pending and in-service bookkeeping; a fresh edge beats the entry clear.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_pending   <= 3'b000;
         r_inservice <= 3'b000;
      end else begin
         r_pending <= (r_pending & ~w_src_oh) | w_irq_rise;
         if (r_state == ST_TAKE) begin
            r_inservice <= r_inservice | w_src_oh;
         end else if (w_eret_take) begin
            r_inservice <= r_inservice & ~w_lvl_oh;
         end
      end
   end

   // EPC stack: push the interrupted PC on entry, pop on return.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_ptr <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            r_stack[i] <= 32'h0000_0000;
         end
      end else if ((r_state == ST_TAKE) && (r_ptr != 2'd3)) begin
         r_ptr <= r_ptr + 2'd1;
         for (int i = 0; i < 3; i++) begin
            if (r_ptr == 2'(i)) begin
               r_stack[i] <= in_pc_next;
            end
         end
      end else if (w_eret_take && (r_ptr != 2'd0)) begin
         r_ptr <= r_ptr - 2'd1;
      end
   end

   // Top of stack, zero when empty.
   always_comb begin
      out_epc = 32'h0000_0000;
      case (r_ptr)
         2'd1:    out_epc = r_stack[0];
         2'd2:    out_epc = r_stack[1];
         2'd3:    out_epc = r_stack[2];
         default: out_epc = 32'h0000_0000;
      endcase
   end

   assign out_take      = (r_state == ST_TAKE);
   assign out_vector    = VEC_BASE + {26'd0, r_src, 4'd0};
   assign out_eret_take = w_eret_take;
   assign out_pending   = r_pending;
   assign out_inservice = r_inservice;
   assign out_mask      = r_mask;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: entry, return, nesting, masking/halt, stray ERET, reset mid-entry.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Every check is an immediate assertion that counts and reports its own miscompare.
module tb_int_sched;

   logic        in_clk;
   logic        in_rst;
   logic [2:0]  in_irq;
   logic [31:0] in_pc_next;
   logic        in_eret;
   logic        in_halt;
   logic        in_mask_we;
   logic [2:0]  in_mask_wdata;
   logic        out_take;
   logic [31:0] out_vector;
   logic        out_eret_take;
   logic [31:0] out_epc;
   logic [2:0]  out_pending;
   logic [2:0]  out_inservice;
   logic [2:0]  out_mask;

   int n_vec = 0;
   int n_err = 0;

   int_sched dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_irq        (in_irq),
      .in_pc_next    (in_pc_next),
      .in_eret       (in_eret),
      .in_halt       (in_halt),
      .in_mask_we    (in_mask_we),
      .in_mask_wdata (in_mask_wdata),
      .out_take      (out_take),
      .out_vector    (out_vector),
      .out_eret_take (out_eret_take),
      .out_epc       (out_epc),
      .out_pending   (out_pending),
      .out_inservice (out_inservice),
      .out_mask      (out_mask)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      in_rst = 1'b1; in_irq = 3'b000; in_pc_next = 32'h0; in_eret = 1'b0;
      in_halt = 1'b0; in_mask_we = 1'b0; in_mask_wdata = 3'b000;
      tick(); tick();
      in_rst = 1'b0;
      #1;
      chk("rst_take",      {31'd0, out_take},      32'd0);
      chk("rst_eret_take", {31'd0, out_eret_take}, 32'd0);
      chk("rst_epc",       out_epc,                32'h0);
      chk("rst_vector",    out_vector,             32'h0000_0400);
      chk("rst_pending",   {29'd0, out_pending},   32'd0);
      chk("rst_inservice", {29'd0, out_inservice}, 32'd0);
      chk("rst_mask",      {29'd0, out_mask},      32'd0);

      // Basic entry of source 0
      in_mask_we = 1'b1; in_mask_wdata = 3'b001;
      tick();
      in_mask_we = 1'b0;
      chk("mask_001", {29'd0, out_mask}, 32'd1);
      in_irq = 3'b001;
      tick();
      chk("b_pending", {29'd0, out_pending}, 32'd1);
      chk("b_no_take_yet", {31'd0, out_take}, 32'd0);
      in_pc_next = 32'h0000_3010;
      tick();
      chk("b_take", {31'd0, out_take}, 32'd1);
      chk("b_vector", out_vector, 32'h0000_0400);
      tick();
      chk("b_take_done", {31'd0, out_take}, 32'd0);
      chk("b_inservice", {29'd0, out_inservice}, 32'd1);
      chk("b_pending_clr", {29'd0, out_pending}, 32'd0);
      chk("b_epc", out_epc, 32'h0000_3010);

      // Return with source 0 re-raised while in service
      in_irq = 3'b000;
      tick();
      in_irq = 3'b001;
      tick();
      chk("r_pending_again", {29'd0, out_pending}, 32'd1);
      chk("r_no_self_preempt", {31'd0, out_take}, 32'd0);
      in_eret = 1'b1;
      #1;
      chk("r_eret_take", {31'd0, out_eret_take}, 32'd1);
      chk("r_eret_epc", out_epc, 32'h0000_3010);
      tick();
      in_eret = 1'b0;
      chk("r_inservice", {29'd0, out_inservice}, 32'd0);
      chk("r_shadow_no_take", {31'd0, out_take}, 32'd0);
      chk("r_epc_empty", out_epc, 32'h0);
      in_pc_next = 32'h0000_5000;
      tick();
      chk("r_after_shadow", {31'd0, out_take}, 32'd0);
      tick();
      chk("r_reenter", {31'd0, out_take}, 32'd1);
      chk("r_reenter_vec", out_vector, 32'h0000_0400);
      tick();
      chk("r_reenter_epc", out_epc, 32'h0000_5000);

      // Nesting: source 2 preempts source 0
      in_mask_we = 1'b1; in_mask_wdata = 3'b111; in_irq = 3'b101;
      tick();
      in_mask_we = 1'b0;
      chk("n_pending2", {29'd0, out_pending}, 32'd4);
      in_pc_next = 32'h0000_6000;
      tick();
      chk("n_take2", {31'd0, out_take}, 32'd1);
      chk("n_vec2", out_vector, 32'h0000_0420);
      tick();
      chk("n_inservice_20", {29'd0, out_inservice}, 32'd5);
      chk("n_epc_depth2", out_epc, 32'h0000_6000);
      in_irq = 3'b111;
      tick();
      chk("n_pending1", {29'd0, out_pending}, 32'd2);
      tick();
      chk("n_src1_waits", {31'd0, out_take}, 32'd0);
      in_eret = 1'b1;
      #1;
      chk("n_eret2_take", {31'd0, out_eret_take}, 32'd1);
      chk("n_eret2_epc", out_epc, 32'h0000_6000);
      tick();
      in_eret = 1'b0;
      chk("n_inservice_0", {29'd0, out_inservice}, 32'd1);
      chk("n_epc_pop", out_epc, 32'h0000_5000);
      chk("n_shadow_no_take", {31'd0, out_take}, 32'd0);
      in_pc_next = 32'h0000_7000;
      tick();
      chk("n_run_no_take", {31'd0, out_take}, 32'd0);
      tick();
      chk("n_take1", {31'd0, out_take}, 32'd1);
      chk("n_vec1", out_vector, 32'h0000_0410);
      tick();
      chk("n_inservice_10", {29'd0, out_inservice}, 32'd3);
      chk("n_epc_7000", out_epc, 32'h0000_7000);
      in_eret = 1'b1;
      #1;
      chk("n_eret1_epc", out_epc, 32'h0000_7000);
      tick();
      in_eret = 1'b0;
      chk("n_after_eret1", {29'd0, out_inservice}, 32'd1);
      tick();
      in_eret = 1'b1;
      #1;
      chk("n_eret0_epc", out_epc, 32'h0000_5000);
      tick();
      in_eret = 1'b0;
      chk("n_all_returned", {29'd0, out_inservice}, 32'd0);
      chk("n_stack_empty", out_epc, 32'h0);
      tick();

      // Masking and halt
      in_mask_we = 1'b1; in_mask_wdata = 3'b000; in_irq = 3'b000;
      tick();
      in_mask_we = 1'b0; in_irq = 3'b010;
      tick();
      chk("m_pending1", {29'd0, out_pending}, 32'd2);
      tick();
      chk("m_masked_no_take", {31'd0, out_take}, 32'd0);
      in_mask_we = 1'b1; in_mask_wdata = 3'b010; in_halt = 1'b1;
      tick();
      in_mask_we = 1'b0;
      chk("m_mask_010", {29'd0, out_mask}, 32'd2);
      tick();
      chk("m_halt_no_take_a", {31'd0, out_take}, 32'd0);
      tick();
      chk("m_halt_no_take_b", {31'd0, out_take}, 32'd0);
      in_halt = 1'b0;
      tick();
      chk("m_take_after_halt", {31'd0, out_take}, 32'd1);
      chk("m_vec1", out_vector, 32'h0000_0410);
      tick();
      chk("m_inservice1", {29'd0, out_inservice}, 32'd2);
      in_halt = 1'b1; in_eret = 1'b1;
      #1;
      chk("m_eret_under_halt", {31'd0, out_eret_take}, 32'd1);
      tick();
      in_eret = 1'b0; in_halt = 1'b0;
      chk("m_returned", {29'd0, out_inservice}, 32'd0);
      tick();

      // Stray ERET
      in_eret = 1'b1;
      #1;
      chk("s_no_eret_take", {31'd0, out_eret_take}, 32'd0);
      tick();
      in_eret = 1'b0;
      chk("s_inservice", {29'd0, out_inservice}, 32'd0);
      chk("s_no_take", {31'd0, out_take}, 32'd0);
      chk("s_epc", out_epc, 32'h0);

      // Reset during TAKE
      in_irq = 3'b000;
      tick();
      in_irq = 3'b010;
      tick();
      tick();
      chk("x_take", {31'd0, out_take}, 32'd1);
      in_rst = 1'b1; in_irq = 3'b000;
      tick();
      chk("x_take_rst", {31'd0, out_take}, 32'd0);
      chk("x_vector_rst", out_vector, 32'h0000_0400);
      chk("x_pending_rst", {29'd0, out_pending}, 32'd0);
      chk("x_inservice_rst", {29'd0, out_inservice}, 32'd0);
      chk("x_mask_rst", {29'd0, out_mask}, 32'd0);
      chk("x_epc_rst", out_epc, 32'h0);
      in_rst = 1'b0; in_eret = 1'b1;
      #1;
      chk("x_eret_after_rst", {31'd0, out_eret_take}, 32'd0);
      tick();
      in_eret = 1'b0;
      chk("x_epc_still_empty", out_epc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
